// File: rtl/team_06_delay_line_ctrl.sv
// Delay-line controller: per audio sample, optionally reads a delayed sample
// from a shared 8192x8 SRAM, gives the effect datapath one cycle to compute the
// new value, then writes that value back at the write pointer.
module team_06_delay_line_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic              echo_en,
  input  logic              reverb_en,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] save_audio,
  output logic [DATA_W-1:0] past_output,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    SETTLE = 3'd2,
    WR_REQ = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [DATA_W-1:0]   past_q, past_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                overrun_q, overrun_d;
  logic                read_ok;

  // A delayed read is only meaningful once that many samples have been stored.
  assign read_ok = (offset != '0) && (fill_cnt_q >= offset);

  // Next-state and register-update logic for the sample transaction FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    offset_d   = offset_q;
    past_d     = past_q;
    wdata_d    = wdata_q;
    // A strobe arriving mid-transaction is dropped and flagged one cycle later.
    overrun_d  = sample_valid && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          offset_d = offset;
          if ((echo_en || reverb_en) && read_ok) begin
            state_d = RD_REQ;
          end else begin
            past_d  = '0;
            state_d = SETTLE;
          end
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          past_d  = mem_rdata;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // Datapath has had one cycle with past_output; freeze its result.
        wdata_d = save_audio;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (mem_ack) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (fill_cnt_q != '1) begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory bus and status outputs decoded from the current state.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = wr_ptr_q - offset_q;
      end
      WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_ptr_q;
        mem_wdata = wdata_q;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign overrun     = overrun_q;
  assign past_output = past_q;

  // Control state and externally visible registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      past_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      past_q     <= past_d;
      overrun_q  <= overrun_d;
    end
  end

  // Transaction-local data; only observed while the FSM is in a state that set it.
  always_ff @(posedge clk) begin
    offset_q <= offset_d;
    wdata_q  <= wdata_d;
  end

endmodule

// File: tb/tb_team_06_delay_line_ctrl.sv
// Directed bench for the delay-line controller with a behavioural SRAM.
module tb_team_06_delay_line_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic        echo_en = 1'b0;
  logic        reverb_en = 1'b0;
  logic [12:0] offset = '0;
  logic [7:0]  save_audio = '0;
  logic [7:0]  past_output;
  logic        mem_req, mem_we, mem_ack;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy, done, overrun;

  logic        ack_hold = 1'b0;
  logic        ack_idle = 1'b0;
  bit   [7:0]  mem [8192];

  int n_chk = 0;
  int n_err = 0;

  // Per-transaction observations collected by txn
  logic        rd_seen, rd_stable, wr_seen, injected;
  logic [12:0] rd_addr, wr_addr;
  logic [7:0]  wr_data;
  int          rd_cycles, lat, ov_cnt;

  team_06_delay_line_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .echo_en      (echo_en),
    .reverb_en    (reverb_en),
    .offset       (offset),
    .save_audio   (save_audio),
    .past_output  (past_output),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  assign mem_ack   = ack_idle | (mem_req & ~ack_hold);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample transaction; hold = RD_REQ cycles with ack withheld,
  // inject = raise sample_valid again while in SETTLE.
  task automatic txn(input logic [7:0] sa, input logic [12:0] off, input logic [1:0] fx,
                     input int hold, input bit inject);
    rd_seen = 0; rd_stable = 1; rd_cycles = 0; wr_seen = 0; injected = 0;
    ov_cnt = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    {reverb_en, echo_en} = fx;
    offset = off; save_audio = sa; ack_hold = 1'b0; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    lat = 1;
    while (lat < 40) begin
      if (overrun) ov_cnt++;
      if (mem_req && !mem_we) begin
        if (rd_seen && mem_addr !== rd_addr) rd_stable = 0;
        rd_seen = 1; rd_addr = mem_addr; rd_cycles++;
        ack_hold = (rd_cycles <= hold);
      end else begin
        ack_hold = 1'b0;
      end
      if (mem_req && mem_we) begin
        wr_seen = 1; wr_addr = mem_addr; wr_data = mem_wdata;
      end
      if (inject && !injected && busy && !mem_req && !done) begin
        sample_valid = 1'b1; injected = 1;
      end else begin
        sample_valid = 1'b0;
      end
      if (done) break;
      step();
      lat++;
    end
    sample_valid = 1'b0;
    ack_hold = 1'b0;
    step();
    if (overrun) ov_cnt++;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_past", past_output, 0);
    rst = 1'b0;

    // Stray ack while idle must not start anything
    ack_idle = 1'b1;
    step(); step(); step();
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_done", done, 0);
    ack_idle = 1'b0;

    // First sample after reset: read skipped, write at 0, 3-cycle latency
    txn(8'h55, 13'd5, 2'b01, 0, 0);
    chk("first_no_read", rd_seen, 0);
    chk("first_past", past_output, 0);
    chk("first_wr_addr", wr_addr, 0);
    chk("first_wr_data", wr_data, 8'h55);
    chk("first_lat", lat, 3);

    // Reset wins over a simultaneous strobe
    rst = 1'b1; sample_valid = 1'b1;
    step();
    chk("rst_prio_busy", busy, 0);
    rst = 1'b0; sample_valid = 1'b0;
    step();
    chk("rst_prio_busy2", busy, 0);

    // Fill with 10,20,30 then 40 reads addr 0 with offset 3
    txn(8'd10, 13'd3, 2'b01, 0, 0);
    chk("s1_wr_addr", wr_addr, 0);
    txn(8'd20, 13'd3, 2'b01, 0, 0);
    txn(8'd30, 13'd3, 2'b01, 0, 0);
    chk("s3_no_read", rd_seen, 0);
    chk("s3_lat", lat, 3);
    txn(8'd40, 13'd3, 2'b01, 0, 0);
    chk("s4_read", rd_seen, 1);
    chk("s4_rd_addr", rd_addr, 0);
    chk("s4_past", past_output, 8'd10);
    chk("s4_wr_addr", wr_addr, 3);
    chk("s4_wr_data", wr_data, 8'd40);
    chk("s4_lat", lat, 4);
    step(); step();
    chk("past_hold", past_output, 8'd10);

    // Strobe during SETTLE: dropped, single overrun, transaction unchanged
    txn(8'd50, 13'd3, 2'b01, 0, 1);
    chk("ovr_rd_addr", rd_addr, 1);
    chk("ovr_past", past_output, 8'd20);
    chk("ovr_count", ov_cnt, 1);
    chk("ovr_wr_addr", wr_addr, 4);
    chk("ovr_wr_data", wr_data, 8'd50);
    chk("ovr_lat", lat, 4);
    chk("ovr_idle", busy, 0);
    txn(8'd66, 13'd1, 2'b01, 0, 0);
    chk("after_ovr_rd_addr", rd_addr, 4);
    chk("after_ovr_past", past_output, 8'd50);
    chk("after_ovr_wr_addr", wr_addr, 5);

    // Read ack held off 3 cycles
    txn(8'd77, 13'd3, 2'b01, 3, 0);
    chk("wait_rd_cycles", rd_cycles, 4);
    chk("wait_rd_stable", rd_stable, 1);
    chk("wait_rd_addr", rd_addr, 3);
    chk("wait_past", past_output, 8'd40);
    chk("wait_lat", lat, 7);
    chk("wait_wr_addr", wr_addr, 6);

    // Reverb alone also reads; no effect still writes
    txn(8'd88, 13'd1, 2'b10, 0, 0);
    chk("rev_rd_addr", rd_addr, 6);
    chk("rev_past", past_output, 8'd77);
    txn(8'd99, 13'd1, 2'b00, 0, 0);
    chk("nofx_no_read", rd_seen, 0);
    chk("nofx_past", past_output, 0);
    chk("nofx_wr_addr", wr_addr, 8);
    chk("nofx_wr_data", wr_data, 8'd99);

    // Reset during a stalled write aborts it
    {reverb_en, echo_en} = 2'b00; save_audio = 8'hAB; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0; ack_hold = 1'b1;
    step();
    chk("abort_wr_req", mem_req, 1);
    chk("abort_wr_addr", mem_addr, 9);
    rst = 1'b1;
    step();
    chk("abort_mem_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0; ack_hold = 1'b0;
    step();
    chk("abort_done2", done, 0);
    txn(8'h00, 13'd4, 2'b00, 0, 0);
    chk("abort_wr_ptr", wr_addr, 0);

    // Advance write pointer to 8190 and check the wrap-around
    for (int i = 1; i < 8190; i++) begin
      txn(i[7:0], 13'd4, 2'b00, 0, 0);
    end
    chk("fill_wr_addr", wr_addr, 8189);
    txn(8'hE0, 13'd4, 2'b01, 0, 0);
    chk("wrap1_rd_addr", rd_addr, 8186);
    chk("wrap1_past", past_output, 8'hFA);
    chk("wrap1_wr_addr", wr_addr, 8190);
    txn(8'hE1, 13'd4, 2'b01, 0, 0);
    chk("wrap2_rd_addr", rd_addr, 8187);
    chk("wrap2_wr_addr", wr_addr, 8191);
    txn(8'hE2, 13'd4, 2'b01, 0, 0);
    chk("wrap3_rd_addr", rd_addr, 8188);
    chk("wrap3_past", past_output, 8'hFC);
    chk("wrap3_wr_addr", wr_addr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
